// File: rtl/slot_alloc24.sv
// -----------------------------------------------------------------------------
// slot_alloc24 - bitmap allocator for up to 24 shared resource slots.
//
// Keeps one busy bit per slot. Each cycle the lowest-numbered free slot is
// found from the registered map. One requester is granted at most one slot per
// cycle, and at most one slot is released per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      frees every slot; takes priority over alloc/free
//   alloc_req  level request for one slot
//   alloc_ack  registered grant pulse; alloc_id is valid with it
//   alloc_id   granted slot index, NONE when there is no grant
//   free_v     release slot free_id this cycle
//   free_id    slot index to release
//   free_err   registered pulse: release of an out-of-range or free slot
//   busy_map   allocated bitmap (bit k = slot k in use)
//   count      number of allocated slots, 0..N
//   full       count == N
//   empty      count == 0
// -----------------------------------------------------------------------------
module slot_alloc24 #(
  parameter int          N    = 24,
  parameter logic [4:0]  NONE = 5'h1F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        alloc_req,
  output logic        alloc_ack,
  output logic [4:0]  alloc_id,
  input  logic        free_v,
  input  logic [4:0]  free_id,
  output logic        free_err,
  output logic [23:0] busy_map,
  output logic [4:0]  count,
  output logic        full,
  output logic        empty
);

  // Slots at or above N do not exist; they are forced busy for the search.
  localparam logic [23:0] VALID_MASK = (N >= 24) ? 24'hFF_FFFF
                                                 : ((24'd1 << N) - 24'd1);
  localparam logic [4:0]  N_SLOTS    = 5'(N);

  // Find-lowest-free encoder: index of the lowest zero bit, NONE if none.
  function automatic logic [4:0] lowest_free(input logic [23:0] busy);
    logic [4:0] idx;
    idx = NONE;
    for (int k = 23; k >= 0; k--) begin
      if (!busy[k]) begin
        idx = 5'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [23:0] busy_q,  busy_d;
  logic [4:0]  count_q, count_d;
  logic        full_q,  full_d;
  logic        empty_q, empty_d;
  logic        ack_q,   ack_d;
  logic [4:0]  id_q,    id_d;
  logic        err_q,   err_d;

  logic [4:0]  found_s;
  logic        grant_s;
  logic        free_ok_s;
  logic [31:0] busy_ext_s;
  logic [31:0] grant_mask_s;
  logic [31:0] free_mask_s;

  // Search, grant/release qualification and next-state computation.
  always_comb begin
    found_s      = lowest_free(busy_q | ~VALID_MASK);
    // Search uses the registered map only, so a same-cycle free is never granted.
    grant_s      = alloc_req && !full_q && (found_s != NONE);
    busy_ext_s   = {8'h00, busy_q};
    // A slot being granted this cycle is not busy yet, so freeing it fails here.
    free_ok_s    = free_v && (free_id < N_SLOTS) && busy_ext_s[free_id];
    grant_mask_s = grant_s   ? (32'd1 << found_s) : 32'd0;
    free_mask_s  = free_ok_s ? (32'd1 << free_id) : 32'd0;

    busy_d  = busy_q;
    count_d = count_q;
    ack_d   = 1'b0;
    id_d    = NONE;
    err_d   = 1'b0;

    if (flush) begin
      busy_d  = 24'd0;
      count_d = 5'd0;
    end else begin
      busy_d = (busy_q | grant_mask_s[23:0]) & ~free_mask_s[23:0];
      case ({grant_s, free_ok_s})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
      ack_d = grant_s;
      id_d  = grant_s ? found_s : NONE;
      err_d = free_v && !free_ok_s;
    end

    full_d  = (count_d == N_SLOTS);
    empty_d = (count_d == 5'd0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 24'd0;
      count_q <= 5'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ack_q   <= 1'b0;
      id_q    <= NONE;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ack_q   <= ack_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign busy_map  = busy_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign alloc_ack = ack_q;
  assign alloc_id  = id_q;
  assign free_err  = err_q;

endmodule
